// File: rtl/result_store_arbiter.sv
// result_store_arbiter: round-robin arbiter that funnels per-core result words
// into one registered output stage, tagging each with its source core index,
// and pulses done once every core has sent its last word and the stage drained.
module result_store_arbiter #(
  parameter int unsigned CORES              = 4,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned CORE_COUNTER_WIDTH = (CORES > 1) ? $clog2(CORES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CORES-1:0]              core_valid,
  input  logic [CORES*DATA_WIDTH-1:0]   core_data,
  input  logic [CORES-1:0]              core_last,
  output logic [CORES-1:0]              core_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CORE_COUNTER_WIDTH-1:0] out_core_id,
  input  logic                          out_ready,
  output logic [15:0]                   result_count,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned IW = CORE_COUNTER_WIDTH;
  // One extra bit so ptr + offset can be compared against CORES before wrapping.
  localparam int unsigned SW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_DRAIN,
    S_FINISH
  } state_e;

  state_e                state_q;
  logic [IW-1:0]         ptr_q;
  logic [CORES-1:0]      done_mask_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [IW-1:0]         out_core_id_q;
  logic [15:0]           result_count_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  slot_free_c;
  logic                  grant_found_c;
  logic [IW-1:0]         grant_idx_c;
  logic [SW-1:0]         scan_c;
  logic                  xfer_c;
  logic [DATA_WIDTH-1:0] grant_data_c;
  logic                  grant_last_c;
  logic [CORES-1:0]      done_mask_d;
  logic [IW-1:0]         ptr_d;

  // Round-robin search from ptr, grant generation and next-pass bookkeeping.
  always_comb begin
    slot_free_c   = !out_valid_q || out_ready;
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    scan_c        = '0;
    for (int k = 0; k < int'(CORES); k++) begin
      scan_c = SW'(ptr_q) + SW'(k);
      if (scan_c >= SW'(CORES)) begin
        scan_c = scan_c - SW'(CORES);
      end
      if (!grant_found_c && core_valid[scan_c[IW-1:0]] && !done_mask_q[scan_c[IW-1:0]]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = scan_c[IW-1:0];
      end
    end

    core_ready = '0;
    if ((state_q == S_ARB) && slot_free_c && grant_found_c) begin
      core_ready[grant_idx_c] = 1'b1;
    end
    // A grant is only ever given to a valid core, so any ready bit is a transfer.
    xfer_c = |core_ready;

    grant_data_c = '0;
    grant_last_c = 1'b0;
    for (int i = 0; i < int'(CORES); i++) begin
      if (IW'(i) == grant_idx_c) begin
        grant_data_c = core_data[i*DATA_WIDTH +: DATA_WIDTH];
        grant_last_c = core_last[i];
      end
    end

    done_mask_d = done_mask_q;
    if (xfer_c && grant_last_c) begin
      done_mask_d[grant_idx_c] = 1'b1;
    end

    ptr_d = (grant_idx_c == IW'(CORES - 1)) ? '0 : grant_idx_c + IW'(1);
  end

  // Pass control FSM, output stage and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      done_mask_q    <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_core_id_q  <= '0;
      result_count_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            done_mask_q    <= '0;
            result_count_q <= '0;
            ptr_q          <= '0;
            busy_q         <= 1'b1;
            state_q        <= S_ARB;
          end
        end
        S_ARB: begin
          if (xfer_c) begin
            out_valid_q   <= 1'b1;
            out_data_q    <= grant_data_c;
            out_core_id_q <= grant_idx_c;
            ptr_q         <= ptr_d;
            done_mask_q   <= done_mask_d;
            if (result_count_q != 16'hFFFF) begin
              result_count_q <= result_count_q + 16'd1;
            end
          end
          if (&done_mask_d) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!out_valid_q || out_ready) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_core_id  = out_core_id_q;
  assign result_count = result_count_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_result_store_arbiter.sv
// tb_result_store_arbiter: randomized stimulus with a transaction-level
// round-robin reference model; expected words go into a scoreboard queue
// that an independent monitor drains whenever the output stage is consumed.
module tb_result_store_arbiter;

  localparam int C  = 4;
  localparam int DW = 32;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [C-1:0]    core_valid;
  logic [C*DW-1:0] core_data;
  logic [C-1:0]    core_last;
  logic [C-1:0]    core_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_core_id;
  logic            out_ready;
  logic [15:0]     result_count;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  result_store_arbiter #(.CORES(C), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .core_valid(core_valid), .core_data(core_data), .core_last(core_last),
    .core_ready(core_ready),
    .out_valid(out_valid), .out_data(out_data), .out_core_id(out_core_id),
    .out_ready(out_ready),
    .result_count(result_count), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] id;
  } item_t;

  item_t    sb_q[$];
  int       id_log[$];
  int       checks   = 0;
  int       fails    = 0;
  bit       mon_en   = 1'b0;
  int       done_cnt = 0;

  // Reference model state: pass-level view of the arbiter.
  int       m_ptr;
  bit [C-1:0] m_done;
  int       m_count;
  bit       m_arb;
  bit       m_busy;
  int       rem[C];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares each consumed output word against the scoreboard head.
  always @(negedge clk) begin
    item_t it;
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
      if (out_valid && out_ready && sb_q.size() != 0) begin
        it = sb_q.pop_front();
        chk("out_data", 64'(out_data), 64'(it.d));
        chk("out_core_id", 64'(out_core_id), 64'(it.id));
        id_log.push_back(int'(out_core_id));
      end
    end
  end

  // One clock of stimulus plus model prediction for the coming edge.
  task automatic cycle(input logic [C-1:0] v, input bit rdy, input bit st);
    int           g;
    int           idx;
    logic [C-1:0] exp_rdy;
    item_t        it;
    @(posedge clk);
    #1;
    start      = st;
    core_valid = v;
    out_ready  = rdy;
    for (int i = 0; i < C; i++) begin
      core_data[i*DW +: DW] = $urandom;
      core_last[i] = m_done[i] ? 1'($urandom) : (rem[i] == 1);
    end
    @(negedge clk);
    #1;
    chk("result_count", 64'(result_count), 64'(m_count));
    chk("busy", 64'(busy), 64'(m_busy));
    if (m_arb || !m_busy) chk("done_quiet", 64'(done), 64'(0));
    if (done) begin
      done_cnt++;
      chk("drained_at_done", 64'(sb_q.size()), 64'(0));
      m_busy = 1'b0;
    end
    exp_rdy = '0;
    g = -1;
    if (m_arb && sb_q.size() == 0) begin
      for (int k = 0; k < C; k++) begin
        idx = (m_ptr + k) % C;
        if (g < 0 && v[idx] && !m_done[idx]) g = idx;
      end
    end
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      it.d  = core_data[g*DW +: DW];
      it.id = CW'(g);
      sb_q.push_back(it);
      m_ptr = (g + 1) % C;
      if (m_count < 65535) m_count++;
      if (core_last[g]) m_done[g] = 1'b1;
      rem[g]--;
      if (&m_done) m_arb = 1'b0;
    end
    chk("core_ready", 64'(core_ready), 64'(exp_rdy));
  endtask

  task automatic start_pass(input int q0, input int q1, input int q2, input int q3);
    rem[0] = q0; rem[1] = q1; rem[2] = q2; rem[3] = q3;
    m_ptr = 0; m_done = '0; m_count = 0; m_arb = 1'b1; m_busy = 1'b1;
    id_log.delete();
    @(posedge clk);
    #1;
    start      = 1'b1;
    core_valid = '0;
    out_ready  = 1'b1;
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < budget && done_cnt == d0; n++) begin
      cycle(C'($urandom), $urandom_range(0, 3) != 0, 1'b0);
    end
    cycle(C'($urandom), 1'b1, 1'b0);
    chk("one_done_pulse", 64'(done_cnt - d0), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_core_ready"}, 64'(core_ready), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_data"}, 64'(out_data), 64'(0));
    chk({tag, "_out_core_id"}, 64'(out_core_id), 64'(0));
    chk({tag, "_result_count"}, 64'(result_count), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    sb_q.delete();
    m_arb = 1'b0; m_busy = 1'b0; m_count = 0; m_done = '0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    int            fair_exp[6] = '{0, 1, 2, 3, 0, 1};
    int            skip_exp[6] = '{0, 2, 3, 0, 2, 3};
    int            n2;
    logic [DW-1:0] held;

    reset = 1'b1; start = 1'b0; core_valid = '0; core_last = '0;
    core_data = '0; out_ready = 1'b0;
    m_ptr = 0; m_done = '0; m_count = 0; m_arb = 1'b0; m_busy = 1'b0;
    for (int i = 0; i < C; i++) rem[i] = 0;

    apply_reset();

    // Fairness: everyone valid, sink always ready.
    start_pass(100, 100, 100, 100);
    repeat (7) cycle(4'hF, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++)
      chk("fair_order", 64'(k < id_log.size() ? id_log[k] : -1), 64'(fair_exp[k]));

    // Backpressure: held word must stay put, no grants, count frozen.
    cycle(4'hF, 1'b0, 1'b0);
    held = out_data;
    cycle(4'hF, 1'b0, 1'b0);
    cycle(4'hF, 1'b0, 1'b0);
    chk("bp_hold_data", 64'(out_data), 64'(held));
    cycle(4'hF, 1'b1, 1'b0);
    cycle(4'hF, 1'b1, 1'b0);

    // Mid-pass reset with a word sitting in the output stage.
    cycle(4'hF, 1'b0, 1'b0);
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    apply_reset();

    // Skip and wrap: core 1 idle, then completes the pass.
    start_pass(2, 1, 2, 2);
    repeat (7) cycle(4'b1101, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++)
      chk("skip_order", 64'(k < id_log.size() ? id_log[k] : -1), 64'(skip_exp[k]));
    run_until_done(200);
    chk("passB_count", 64'(result_count), 64'(7));

    // Completion: core 2 finishes on its first word; stray start mid-pass.
    start_pass(3, 3, 1, 3);
    repeat (4) cycle(C'($urandom), 1'b1, 1'b0);
    cycle(C'($urandom), 1'b1, 1'b1);
    run_until_done(300);
    chk("passC_count", 64'(result_count), 64'(10));
    n2 = 0;
    foreach (id_log[k]) if (id_log[k] == 2) n2++;
    chk("core2_single_grant", 64'(n2), 64'(1));
    chk("passC_busy_low", 64'(busy), 64'(0));

    // Random passes.
    for (int p = 0; p < 3; p++) begin
      start_pass($urandom_range(1, 6), $urandom_range(1, 6),
                 $urandom_range(1, 6), $urandom_range(1, 6));
      run_until_done(400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/result_store_arbiter.md
# result_store_arbiter

Round-robin arbiter that shares the single result-store write path among `CORES` processing cores. It collects result words from each core over valid/ready handshakes and tracks per-core completion via a `last` flag. It presents the granted words, tagged with the source core index, to the result store / output FIFO through one registered output stage. It pulses `done` once every core has delivered its final result and the output stage has drained.

## Interface
Parameters:
- `CORES`, default 4: number of requesting cores, 1..16.
- `DATA_WIDTH`, default 32: width of one result word.
- `CORE_COUNTER_WIDTH`, default `log2(CORES)`, minimum 1: width of the core index.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a collection pass.
- `core_valid`  in  CORES  per-core result available.
- `core_data`  in  CORES*DATA_WIDTH  per-core result word; core i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `core_last`  in  CORES  qualifies `core_valid`: this word is the core's final result.
- `core_ready`  out  CORES  one-hot grant; a transfer happens when `core_valid[i] && core_ready[i]`.
- `out_valid`  out  1  output stage holds a word.
- `out_data`  out  DATA_WIDTH  granted word.
- `out_core_id`  out  CORE_COUNTER_WIDTH  source core of `out_data`.
- `out_ready`  in  1  downstream accepts the word when `out_valid && out_ready`.
- `result_count`  out  16  words accepted this pass, saturating at 0xFFFF.
- `busy`  out  1  high in every state except S_Idle.
- `done`  out  1  single-cycle pulse when the pass completes.

## Operation
- State machine: S_Idle, S_Arb, S_Drain, S_Finish.
- S_Idle:
  - On `start`: clear `done_mask`, `result_count` and `ptr`; go to S_Arb.
  - Otherwise remain.
- S_Arb:
  - Define slot_free = `!out_valid || out_ready`.
  - If slot_free, grant the first core i, searching from `ptr` upward with wrap, that has `core_valid[i] && !done_mask[i]`.
  - `core_ready[i]` is combinational and asserted only for that core. It is zero for all cores when slot_free is false or no core is eligible.
  - On a transfer:
    - `out_data` <= word, `out_core_id` <= i, `out_valid` <= 1.
    - `ptr` <= (i+1) wrapped at CORES, with explicit wrap for non-power-of-two CORES.
    - `result_count` increments, saturating.
    - If `core_last[i]`, `done_mask[i]` <= 1.
  - When `done_mask` (including this cycle's update) is all ones, go to S_Drain.
- Cores with `done_mask` set are never granted again in this pass, regardless of `core_valid`.
- Without a new transfer, `out_valid && out_ready` clears `out_valid`.
- S_Drain: no grants. Once `out_valid` is 0, or is being consumed this cycle, go to S_Finish.
- S_Finish: `done` = 1 for exactly this cycle; next state S_Idle. `result_count` holds its value until the next `start`.
- `start` outside S_Idle is ignored.
- `CORES` = 1: `ptr` is constant 0, and the block degenerates to a registered pass-through.

## Timing
- Reset values: all outputs 0, including `core_ready`, `out_valid`, `out_data`, `out_core_id`, `result_count`, `busy` and `done`. Internal state: S_Idle, `ptr` = 0, `done_mask` = 0.
- Reset mid-pass returns to S_Idle on the next edge. Any word in the output stage is dropped (`out_valid` = 0).
- Latency: a core transfer in cycle N gives `out_valid` = 1 in cycle N+1.
- Throughput: one word per cycle while `out_ready` is held high, with simultaneous consume and refill.
- Under backpressure (`out_valid && !out_ready`):
  - `out_data` and `out_core_id` are held stable.
  - All `core_ready` bits are 0.
  - `result_count` is unchanged.
- `busy` rises the cycle after `start` and falls the cycle after the `done` pulse.
- `core_ready` has a combinational path from `core_valid` and `out_ready`. Upstream cores must not drive `core_valid` from `core_ready`.

## Test plan
- Reset: assert `reset` for 2 cycles mid-pass, with `out_valid` = 1 beforehand -> all outputs 0 the following cycle; a new `start` begins a clean pass.
- Fairness (CORES=4, all `core_valid`=1, `out_ready`=1) -> `out_core_id` sequence 0,1,2,3,0,1 on consecutive cycles; `result_count` increments by 1 per cycle.
- Skip and wrap: only cores 0, 2 and 3 valid -> grant order 0,2,3,0,2,3; `ptr` wraps from 3 to 0.
- Backpressure: drop `out_ready` for 3 cycles with a word held -> `out_data` stable, `core_ready` = 0, count frozen; transfers resume the cycle `out_ready` returns.
- Completion: core 2 sends `last` on its first word; the others send 3 words each, the third with `last` -> core 2 is never granted again; `done` pulses once after the final word is consumed; `result_count` = 10; `busy` then 0.
- `start` during S_Arb -> ignored; the pass completes normally with one `done` pulse.
